// File: rtl/sgd_update.sv
// sgd_update: register-held W/b with a plain SGD pass (W -= lr*dw, b -= lr*db); SGD_SATURATE_EN selects clamp vs wrap.
// Latency: start -> done is M*N+M+1 cycles, one element per cycle; init_load is visible the next cycle.
// Backpressure: none; start/init_load are ignored outside IDLE, so the caller waits for done.
module sgd_update #(
  parameter int M = 5,
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_load,
  input  logic signed [15:0] init_W [0:M-1][0:N-1],
  input  logic signed [15:0] init_b [0:M-1][0:0],
  input  logic               start,
  input  logic signed [15:0] lr,
  input  logic signed [15:0] dw     [0:M-1][0:N-1],
  input  logic signed [15:0] db     [0:M-1][0:0],
  output logic signed [15:0] W      [0:M-1][0:N-1],
  output logic signed [15:0] b      [0:M-1][0:0],
  output logic               busy,
  output logic               done
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, UPD_W, UPD_B, DONE} state_t;

  state_t             state;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic signed [15:0] lr_q;
  logic signed [15:0] dw_q [0:M-1][0:N-1];
  logic signed [15:0] db_q [0:M-1][0:0];

  function automatic logic signed [15:0] reduce16(input logic signed [31:0] v);
`ifdef SGD_SATURATE_EN
    if (v > 32'sd32767)
      return 16'sh7FFF;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  // Q8.8 * Q8.8 gives Q16.16; the floor shift brings it back to Q8.8.
  function automatic logic signed [15:0] sgd_step(input logic signed [15:0] old,
                                                  input logic signed [15:0] g,
                                                  input logic signed [15:0] rate);
    logic signed [31:0] p;
    logic signed [15:0] q;
    logic signed [16:0] d;
    p = 32'(rate) * 32'(g);
    q = reduce16(p >>> 8);
    d = 17'(old) - 17'(q);
    return reduce16(32'(d));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lr_q  <= '0;
      for (int r = 0; r < M; r++) begin
        b[r][0]    <= '0;
        db_q[r][0] <= '0;
        for (int c = 0; c < N; c++) begin
          W[r][c]    <= '0;
          dw_q[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (init_load) begin
            W <= init_W;
            b <= init_b;
          end else if (start) begin
            lr_q  <= lr;
            dw_q  <= dw;
            db_q  <= db;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
            state <= UPD_W;
          end
        end
        UPD_W: begin
          W[row][col] <= sgd_step(W[row][col], dw_q[row][col], lr_q);
          if (col == C_LAST) begin
            col <= '0;
            if (row == R_LAST) begin
              row   <= '0;
              state <= UPD_B;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        UPD_B: begin
          b[row][0] <= sgd_step(b[row][0], db_q[row][0], lr_q);
          if (row == R_LAST) begin
            row   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row <= row + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgd_update.sv
// Bench for sgd_update: scoreboard of expected post-pass W/b, popped on each done pulse.
`timescale 1ns/1ps
module tb_sgd_update;
  localparam int M  = 5;
  localparam int N  = 3;
  localparam int MN = M * N;

  logic               clk = 1'b0;
  logic               reset;
  logic               init_load;
  logic               start;
  logic signed [15:0] lr;
  logic signed [15:0] init_W [0:M-1][0:N-1];
  logic signed [15:0] init_b [0:M-1][0:0];
  logic signed [15:0] dw     [0:M-1][0:N-1];
  logic signed [15:0] db     [0:M-1][0:0];
  logic signed [15:0] W      [0:M-1][0:N-1];
  logic signed [15:0] b      [0:M-1][0:0];
  logic               busy;
  logic               done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int cnt0;

  logic [15:0] mw   [MN];
  logic [15:0] mb   [M];
  logic [15:0] oldw [MN];

  typedef struct packed {
    logic [MN-1:0][15:0] w;
    logic [M-1:0][15:0]  b;
  } exp_t;
  exp_t exp_q[$];

  sgd_update #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .init_load(init_load), .init_W(init_W), .init_b(init_b),
    .start(start), .lr(lr), .dw(dw), .db(db), .W(W), .b(b), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] red(input longint v);
`ifdef SGD_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  function automatic logic [15:0] upd(input logic [15:0] old, input logic [15:0] g,
                                      input logic [15:0] rate);
    longint p, rem, q;
    p   = longint'($signed(rate)) * longint'($signed(g));
    rem = ((p % 256) + 256) % 256;
    q   = (p - rem) / 256;
    return red(longint'($signed(old)) - longint'($signed(red(q))));
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < MN; k++)
          check($sformatf("sb_w%0d", k), W[k / N][k % N], e.w[k]);
        for (int r = 0; r < M; r++)
          check($sformatf("sb_b%0d", r), b[r][0], e.b[r]);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < MN; k++) mw[k] = '0;
    for (int r = 0; r < M; r++) mb[r] = '0;
    exp_q.delete();
  endtask

  task automatic load(input logic [15:0] wv, input logic [15:0] w00, input logic [15:0] bv,
                      input logic with_start);
    @(negedge clk);
    for (int r = 0; r < M; r++) begin
      init_b[r][0] = bv;
      mb[r] = bv;
      for (int c = 0; c < N; c++) begin
        init_W[r][c] = (r == 0 && c == 0) ? w00 : wv;
        mw[r*N+c] = (r == 0 && c == 0) ? w00 : wv;
      end
    end
    init_load = 1'b1;
    start     = with_start;
    @(negedge clk);
    init_load = 1'b0;
    start     = 1'b0;
    check("load_w00", W[0][0], w00);
    check("load_wlast", W[M-1][N-1], wv);
    check("load_blast", b[M-1][0], bv);
    check("load_busy", busy, 16'd0);
  endtask

  task automatic set_grad(input logic [15:0] dwv, input logic [15:0] dbv, input logic [15:0] lrv);
    lr = lrv;
    for (int r = 0; r < M; r++) begin
      db[r][0] = dbv;
      for (int c = 0; c < N; c++) dw[r][c] = dwv;
    end
  endtask

  // Called at a negedge; returns 1ns after the edge that samples start.
  task automatic begin_pass();
    exp_t e;
    start = 1'b1;
    for (int k = 0; k < MN; k++) begin
      oldw[k] = mw[k];
      mw[k]   = upd(mw[k], dw[k / N][k % N], lr);
      e.w[k]  = mw[k];
    end
    for (int r = 0; r < M; r++) begin
      mb[r]  = upd(mb[r], db[r][0], lr);
      e.b[r] = mb[r];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic timed_pass(input string nm);
    begin_pass();
    for (int j = 0; j <= MN + M + 1; j++) begin
      @(negedge clk);
      check($sformatf("%s_busy_c%0d", nm, j + 1), busy, (j <= MN + M - 1) ? 16'd1 : 16'd0);
      check($sformatf("%s_done_c%0d", nm, j + 1), done, (j == MN + M) ? 16'd1 : 16'd0);
      if (j >= 1 && j <= MN)
        check($sformatf("%s_flip%0d", nm, j - 1), W[(j-1) / N][(j-1) % N], mw[j-1]);
      if (j < MN)
        check($sformatf("%s_hold%0d", nm, j), W[j / N][j % N], oldw[j]);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 16'd0, 16'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; init_load = 1'b0; start = 1'b0;
    set_grad(16'h0, 16'h0, 16'h0);
    for (int r = 0; r < M; r++) begin
      init_b[r][0] = '0;
      for (int c = 0; c < N; c++) init_W[r][c] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_w00", W[0][0], 16'h0);
    check("rst_busy", busy, 16'd0);
    reset = 1'b0;

    // Asynchronous reset mid-cycle clears nonzero state without a clock edge.
    load(16'h1234, 16'h1234, 16'h0567, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < MN; k++) check($sformatf("arst_w%0d", k), W[k / N][k % N], 16'h0);
    for (int r = 0; r < M; r++) check($sformatf("arst_b%0d", r), b[r][0], 16'h0);
    check("arst_busy", busy, 16'd0);
    check("arst_done", done, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Nominal pass with per-element timing.
    load(16'h0100, 16'h0100, 16'h0080, 1'b0);
    set_grad(16'h0200, 16'h0100, 16'h0080);
    cnt0 = done_cnt;
    timed_pass("nom");
    check("nom_w21", W[2][1], 16'h0000);
    check("nom_b4", b[4][0], 16'h0000);
    check("nom_done_cnt", 16'(done_cnt - cnt0), 16'd1);

    // Overflow on W[0][0].
    load(16'h0000, 16'h8010, 16'h0000, 1'b0);
    set_grad(16'h0000, 16'h0000, 16'h0100);
    dw[0][0] = 16'h0100;
    begin_pass();
    wait_done();
`ifdef SGD_SATURATE_EN
    check("ovf_w00", W[0][0], 16'h8000);
`else
    check("ovf_w00", W[0][0], 16'h7F10);
`endif

    // Snapshot: gradients change mid-pass, a second start mid-pass is ignored.
    load(16'h0200, 16'h0200, 16'h0000, 1'b0);
    set_grad(16'h0100, 16'h0000, 16'h0100);
    cnt0 = done_cnt;
    begin_pass();
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) set_grad(16'h7FFF, 16'h7FFF, 16'h7FFF);
      if (j == 4) start = 1'b1;
      if (j == 5) start = 1'b0;
    end
    for (int k = 0; k < MN; k++) check($sformatf("snap_w%0d", k), W[k / N][k % N], 16'h0100);
    check("snap_b0", b[0][0], 16'h0000);
    check("snap_busy", busy, 16'd0);
    check("snap_done_cnt", 16'(done_cnt - cnt0), 16'd1);

    // Reset in cycle t+8 aborts the pass.
    load(16'h0300, 16'h0300, 16'h0100, 1'b0);
    set_grad(16'h0100, 16'h0100, 16'h0100);
    cnt0 = done_cnt;
    begin_pass();
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int k = 0; k < MN; k++) check($sformatf("mrst_w%0d", k), W[k / N][k % N], 16'h0);
    for (int r = 0; r < M; r++) check($sformatf("mrst_b%0d", r), b[r][0], 16'h0);
    check("mrst_busy", busy, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("mrst_no_done", 16'(done_cnt - cnt0), 16'd0);
    set_grad(16'h0100, 16'h0100, 16'h0100);
    timed_pass("post");
    check("post_w00", W[0][0], 16'hFF00);
    check("post_b0", b[0][0], 16'hFF00);
    check("post_done_cnt", 16'(done_cnt - cnt0), 16'd1);

    // init_load beats start in the same cycle.
    set_grad(16'h0100, 16'h0100, 16'h0100);
    cnt0 = done_cnt;
    load(16'h0AAA, 16'h0AAA, 16'h0555, 1'b1);
    repeat (25) @(negedge clk);
    check("prio_busy", busy, 16'd0);
    check("prio_w12", W[1][2], 16'h0AAA);
    check("prio_b3", b[3][0], 16'h0555);
    check("prio_no_done", 16'(done_cnt - cnt0), 16'd0);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sgd_update.md
# sgd_update

Parameter-update engine that closes the training loop between `backward_neurons` and `forward_neurons`. It holds the layer's weight matrix and bias vector in registers and drives them continuously to the forward path. On a `start` request it snapshots the gradient outputs of the backward path (`dw`, `db`) and the learning rate. It then applies plain SGD (`W ← W − lr·dw`, `b ← b − lr·db`) one element per clock and signals completion.

## Interface
- `M`, default 5: neurons (rows of W, length of b).
- `N`, default 3: inputs per neuron (columns of W).

- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `init_load` input, 1 bit: load `init_W`/`init_b` into parameter registers.
- `init_W` input, data_type [0:M-1][0:N-1]: initial weights.
- `init_b` input, data_type [0:M-1][0:0]: initial biases.
- `start` input, 1 bit: request one update pass.
- `lr` input, data_type: learning rate.
- `dw` input, data_type [0:M-1][0:N-1]: weight gradient.
- `db` input, data_type [0:M-1][0:0]: bias gradient.
- `W` output, data_type [0:M-1][0:N-1]: current weights.
- `b` output, data_type [0:M-1][0:0]: current biases.
- `busy` output, 1 bit: update pass in progress.
- `done` output, 1 bit: one-cycle completion pulse.

data_type is 16-bit signed Q8.8.

## Operation
- FSM states: IDLE, UPD_W, UPD_B, DONE.
- IDLE:
  - `init_load`=1: copy `init_W`/`init_b` into the registers at that edge and stay in IDLE.
  - Otherwise `start`=1: snapshot `dw`, `db`, `lr` into internal registers, clear row/col counters, go to UPD_W.
  - `init_load` and `start` together: init wins; start is dropped.
- UPD_W: each cycle update `W[r][c]` in row-major order (c fastest). After `W[M-1][N-1]`, go to UPD_B with r=0.
- UPD_B: each cycle update `b[r]`. After `b[M-1]`, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` and `init_load` are ignored outside IDLE.
- Live `dw`/`db`/`lr` changes after the snapshot have no effect on the pass.
- Arithmetic per element:
  - p = lr·g, a 32-bit signed product.
  - q = p >>> 8 (arithmetic shift, floor).
  - q is reduced to 16 bits (see Configuration).
  - new = old − q, computed in 17 bits, then reduced to 16 bits (see Configuration).
- Reset: all W and b registers = 0x0000, `busy`=0, `done`=0, state IDLE, counters 0, snapshot registers 0.
  - Reset mid-pass aborts immediately.
  - Elements already updated are cleared as well; no `done` pulse is produced.

## Timing
- `start` sampled at edge t (in IDLE).
- `busy`=1 from cycle t+1 through cycle t+M·N+M.
- W element k (row-major index) takes its new value at edge t+1+k; it is visible on `W` from that cycle on.
- b[r] takes its new value at edge t+1+M·N+r.
- `done`=1 during cycle t+M·N+M+1, with `busy`=0.
- Earliest next accepted `start` is at edge t+M·N+M+2.
- Defaults: 20 update cycles; `done` at t+21.
- `init_load` takes effect at the sampling edge (one-cycle latency to outputs).
- `W`/`b` are registered outputs and are never combinationally dependent on inputs.

## Configuration
- `SGD_SATURATE_EN` defined: both the q reduction and the new-value reduction clamp to [0x8000, 0x7FFF].
- `SGD_SATURATE_EN` undefined: both reductions keep the low 16 bits (two's-complement wrap).
- No other behaviour changes; timing is identical in both builds.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `W`, `b` all 0x0000; `busy`=0; `done`=0 immediately, without waiting for a clock.
- Nominal pass:
  - Stimulus: `init_load` with all W=0x0100, b=0x0080; then `start` with lr=0x0080, dw all 0x0200, db all 0x0100.
  - Response: all W=0x0000 and all b=0x0000; `busy` high for 20 cycles; `done` pulses exactly at t+21.
  - Check each W element flips at edge t+1+k in row-major order.
- Overflow:
  - Stimulus: W[0][0]=0x8010, lr=0x0100, dw[0][0]=0x0100.
  - Response with `SGD_SATURATE_EN`: W[0][0]=0x8000. Without it: W[0][0]=0x7F10.
- Snapshot:
  - Stimulus: start with dw all 0x0100, lr=0x0100, W all 0x0200; change dw to 0x7FFF at t+2.
  - Response: all W=0x0100.
  - Also: a second `start` at t+5 is ignored (still exactly one `done`).
- Reset mid-pass: assert `reset` at cycle t+8 → all parameters 0x0000, state IDLE, no `done`; a subsequent `start` runs a full 20-cycle pass.
- Priority: in IDLE assert `init_load` and `start` in the same cycle → registers equal `init_W`/`init_b`, `busy` stays 0, no `done`.
